// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Op encoding doubles as the HI/LO source mux select.
package mult_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        WB,
        ERR
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER_W = 6;

endpackage

// File: rtl/mult_div_ctrl_iter_counter.sv
// Clear/enable up-counter with a terminal-count flag at ITER-1.
// The count never wraps because the sequencer leaves RUN on the terminal flag.
module iter_counter
    import mult_div_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [ITER_W-1:0] LAST = ITER_W'(ITER - 1);

    logic [ITER_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == LAST);

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer for the multi-cycle multiply/divide units: init/step strobes,
// HI/LO source select and write enables, done / divide-by-zero handshake.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mult_start,
    input  logic div_start,
    input  logic divisor_zero,
    output logic mult_init,
    output logic mult_step,
    output logic div_init,
    output logic div_step,
    output logic hi_lo_sel,
    output logic hi_write,
    output logic lo_write,
    output logic busy,
    output logic done,
    output logic div_zero_exc
);

    state_t state_reg;
    logic   op_reg;
    logic   last_iter;

    iter_counter #(
        .ITER (ITER)
    ) u_iter_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_reg == INIT),
        .en      (state_reg == RUN),
        .tc      (last_iter)
    );

    assign hi_lo_sel = op_reg;

    // Outputs are registered together with the state they belong to, so each
    // strobe is loaded on the same edge that enters its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            op_reg       <= OP_MULT;
            mult_init    <= 1'b0;
            mult_step    <= 1'b0;
            div_init     <= 1'b0;
            div_step     <= 1'b0;
            hi_write     <= 1'b0;
            lo_write     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
        end else begin
            mult_init    <= 1'b0;
            mult_step    <= 1'b0;
            div_init     <= 1'b0;
            div_step     <= 1'b0;
            hi_write     <= 1'b0;
            lo_write     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    // Multiply wins when both starts arrive together.
                    if (mult_start) begin
                        op_reg    <= OP_MULT;
                        state_reg <= INIT;
                        mult_init <= 1'b1;
                        busy      <= 1'b1;
                    end else if (div_start) begin
                        op_reg <= OP_DIV;
                        busy   <= 1'b1;
                        if (divisor_zero) begin
                            state_reg    <= ERR;
                            div_zero_exc <= 1'b1;
                            done         <= 1'b1;
                        end else begin
                            state_reg <= INIT;
                            div_init  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    state_reg <= RUN;
                    mult_step <= (op_reg == OP_MULT);
                    div_step  <= (op_reg == OP_DIV);
                    busy      <= 1'b1;
                end
                RUN: begin
                    busy <= 1'b1;
                    if (last_iter) begin
                        state_reg <= WB;
                        hi_write  <= 1'b1;
                        lo_write  <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        mult_step <= (op_reg == OP_MULT);
                        div_step  <= (op_reg == OP_DIV);
                    end
                end
                WB: begin
                    state_reg <= IDLE;
                end
                ERR: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: two instances (ITER=32 and ITER=1) share stimulus
// and are checked each cycle against a timeline model of the operation.
module tb_mult_div_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mult_start = 1'b0;
    logic div_start = 1'b0;
    logic divisor_zero = 1'b0;

    logic [1:0] mi, ms, di, ds, sel, hw, lw, bsy, dn, dze;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Timeline model: k counts cycles since the accepting edge (k=1 first busy cycle).
    int  par_iter [2] = '{32, 1};
    bit  act [2];
    int  k   [2];
    bit  mop [2];
    bit  merr[2];

    always #5 clk = ~clk;

    mult_div_ctrl #(.ITER(32)) dut0 (
        .clk(clk), .reset_n(reset_n), .mult_start(mult_start), .div_start(div_start),
        .divisor_zero(divisor_zero), .mult_init(mi[0]), .mult_step(ms[0]), .div_init(di[0]),
        .div_step(ds[0]), .hi_lo_sel(sel[0]), .hi_write(hw[0]), .lo_write(lw[0]),
        .busy(bsy[0]), .done(dn[0]), .div_zero_exc(dze[0])
    );

    mult_div_ctrl #(.ITER(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .mult_start(mult_start), .div_start(div_start),
        .divisor_zero(divisor_zero), .mult_init(mi[1]), .mult_step(ms[1]), .div_init(di[1]),
        .div_step(ds[1]), .hi_lo_sel(sel[1]), .hi_write(hw[1]), .lo_write(lw[1]),
        .busy(bsy[1]), .done(dn[1]), .div_zero_exc(dze[1])
    );

    task automatic chk(input string tag, input int d, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc %0d: got %b want %b", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; k[d] = 0; mop[d] = 1'b0; merr[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                act[d] = 1'b0; k[d] = 0; mop[d] = 1'b0; merr[d] = 1'b0;
            end else if (act[d]) begin
                k[d]++;
                if (k[d] > (merr[d] ? 1 : par_iter[d] + 2)) act[d] = 1'b0;
            end else if (mult_start === 1'b1) begin
                act[d] = 1'b1; k[d] = 1; mop[d] = 1'b0; merr[d] = 1'b0;
            end else if (div_start === 1'b1) begin
                act[d] = 1'b1; k[d] = 1; mop[d] = 1'b1; merr[d] = divisor_zero;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            bit run_ok, init_c, step_c, wb_c, err_c;
            run_ok = act[d] && !merr[d];
            init_c = run_ok && k[d] == 1;
            step_c = run_ok && k[d] >= 2 && k[d] <= par_iter[d] + 1;
            wb_c   = run_ok && k[d] == par_iter[d] + 2;
            err_c  = act[d] && merr[d];
            chk("mult_init", d, mi[d],  init_c && !mop[d]);
            chk("mult_step", d, ms[d],  step_c && !mop[d]);
            chk("div_init",  d, di[d],  init_c && mop[d]);
            chk("div_step",  d, ds[d],  step_c && mop[d]);
            chk("hi_lo_sel", d, sel[d], mop[d]);
            chk("hi_write",  d, hw[d],  wb_c);
            chk("lo_write",  d, lw[d],  wb_c);
            chk("busy",      d, bsy[d], act[d]);
            chk("done",      d, dn[d],  wb_c || err_c);
            chk("div_zero",  d, dze[d], err_c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
    task automatic async_reset(input int hold);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < hold; i++) tick();
        #2;
        reset_n = 1'b1;
    endtask

    int n_step;
    int n_done;

    initial begin
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset_n = 1'b1;
        tick();

        // Multiply pulse, divisor_zero unknown: exactly 32 step cycles.
        mult_start = 1'b1; divisor_zero = 1'bx;
        tick();
        mult_start = 1'b0;
        n_step = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (ms[0] === 1'b1) n_step++;
        end
        chk("mult_step_count", 0, logic'(n_step == 32), 1'b1);

        // Divide with nonzero divisor.
        div_start = 1'b1; divisor_zero = 1'b0;
        tick();
        div_start = 1'b0;
        n_step = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (ds[0] === 1'b1) n_step++;
        end
        chk("div_step_count", 0, logic'(n_step == 32), 1'b1);

        // Divide by zero.
        div_start = 1'b1; divisor_zero = 1'b1;
        tick();
        div_start = 1'b0; divisor_zero = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Both starts together, then a divide start during RUN is ignored.
        mult_start = 1'b1; div_start = 1'b1;
        tick();
        mult_start = 1'b0; div_start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 40; c++) begin
            div_start = (c == 10);
            tick();
            if (dn[0] === 1'b1) n_done++;
        end
        div_start = 1'b0;
        chk("single_done", 0, logic'(n_done == 1), 1'b1);

        // Reset in the middle of a divide, then a clean multiply.
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        async_reset(2);
        tick();
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        for (int i = 0; i < 36; i++) tick();

        // Continuous multiply start: back-to-back operations.
        mult_start = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dn[1] === 1'b1) n_done++;
        end
        mult_start = 1'b0;
        chk("iter1_done_count", 1, logic'(n_done == 5), 1'b1);
        for (int i = 0; i < 40; i++) tick();

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            mult_start   = ($urandom_range(0, 7) == 0);
            div_start    = ($urandom_range(0, 5) == 0);
            divisor_zero = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) async_reset(1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Sequencer for the multi-cycle multiply and divide units feeding the HI/LO registers. It accepts a start request from the main control FSM and drives init/step strobes to the selected unit for a fixed iteration count. It then steers the HI/LO source muxes (0 = multiplier, 1 = divider) and pulses the HI/LO write enables. A done or exception handshake is returned to the control FSM.

## Interface
- ITER, 32, number of step cycles per operation; legal range 1..63
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- mult_start  input  1  request MULT/MULTU; sampled only in IDLE
- div_start  input  1  request DIV/DIVU; sampled only in IDLE
- divisor_zero  input  1  divider operand B == 0; sampled with div_start
- mult_init  output  1  one-cycle load strobe to multiplier
- mult_step  output  1  multiplier iteration enable
- div_init  output  1  one-cycle load strobe to divider
- div_step  output  1  divider iteration enable
- hi_lo_sel  output  1  seletor for HI and LO source muxes: 0 = mult, 1 = div
- hi_write  output  1  HI register write enable
- lo_write  output  1  LO register write enable
- busy  output  1  operation in progress; the control FSM stalls MFHI/MFLO and new starts
- done  output  1  one-cycle completion pulse
- div_zero_exc  output  1  one-cycle divide-by-zero exception pulse

## Operation
- States: IDLE, INIT, RUN, WB, ERR. All outputs are Moore, decoded from state plus the op register.
- IDLE:
  - mult_start=1: op←MULT, go to INIT.
  - div_start=1 and divisor_zero=0: op←DIV, go to INIT.
  - div_start=1 and divisor_zero=1: op←DIV, go to ERR.
  - Both starts high: mult wins and div_start is dropped.
- INIT: assert mult_init or div_init according to op. Counter←0. Go to RUN.
- RUN: assert mult_step or div_step according to op. Counter increments each cycle. When counter == ITER-1, go to WB.
- WB: assert hi_write=1, lo_write=1 and done=1. Go to IDLE.
- ERR: assert div_zero_exc=1 and done=1. No HI/LO write. Go to IDLE.
- hi_lo_sel = op register. It is registered and holds its value after completion until the next accepted start.
- busy = (state != IDLE).
- Starts outside IDLE are ignored, with no queuing.
- Counter width is 6 bits. It never wraps because the terminal compare occurs at ITER-1.
- Reset (any state, including mid-RUN):
  - state←IDLE, op←MULT, counter←0.
  - All outputs 0 (hi_lo_sel=0, busy=0).
  - No write strobe is ever issued for an aborted operation.

## Timing
- Start is accepted on edge 0, i.e. the start input is high in cycle 0 while in IDLE.
- Normal operation:
  - INIT occupies cycle 1.
  - RUN occupies cycles 2..ITER+1.
  - WB occupies cycle ITER+2, with done and write enables high.
  - IDLE resumes in cycle ITER+3. With ITER=32: WB in cycle 34, busy high in cycles 1..34.
- Divide-by-zero: ERR in cycle 1, busy high in cycle 1 only, IDLE in cycle 2.
- A start held high through WB is accepted again in the first IDLE cycle. The earliest back-to-back restart is at cycle ITER+3.
- hi_lo_sel is stable from cycle 1 through WB. The datapath registers HI/LO on the clock edge that ends WB.
- Strobes never overlap: mult_* and div_* are mutually exclusive, and init/step are exclusive.

## Structure
- Shared package mult_div_pkg:
  - state enum: IDLE, INIT, RUN, WB, ERR
  - op constants: OP_MULT=1'b0, OP_DIV=1'b1. These values match the mux seletor encoding.
  - ITER_W=6
- One sub-module, iter_counter: a clear/enable up-counter with a terminal-count flag, parameterised by ITER, with asynchronous active-low reset.
- The FSM and output decode live in mult_div_ctrl.

## Test plan
- ITER=32; pulse mult_start with divisor_zero=X:
  - mult_init in cycle 1 only; mult_step high for exactly 32 cycles (2..33).
  - In cycle 34: hi_write=lo_write=done=1 and hi_lo_sel=0.
  - busy low in cycle 35.
- div_start with divisor_zero=0: same timeline on div_init/div_step, with hi_lo_sel=1 from cycle 1 through 34.
- div_start with divisor_zero=1: cycle 1 has div_zero_exc=1 and done=1; hi_write=lo_write=0 throughout; busy low in cycle 2.
- mult_start and div_start high together: multiplier path runs, div_* never asserted, hi_lo_sel=0. Then div_start pulsed in cycle 10 (during RUN) is ignored: only one done, in cycle 34.
- reset_n driven low asynchronously mid-cycle at cycle 20 of a divide:
  - All outputs 0 immediately, with no WB.
  - After release, a mult_start completes normally with hi_lo_sel=0.
- ITER=1: mult start gives INIT in cycle 1, a single step in cycle 2, WB in cycle 3. Continuous mult_start gives back-to-back operations with done every 4 cycles.
